// File: rtl/maze_player_ctrl.sv
// Grid player mover: one cell per accepted tick, wall check via req/ack lookup.
// Edge moves are rejected locally; held directions auto-repeat after a hold-off.
module maze_player_ctrl #(
    parameter int COORD_W      = 11,
    parameter int MAZE_W       = 40,
    parameter int MAZE_H       = 30,
    parameter int START_X      = 1,
    parameter int START_Y      = 1,
    parameter int REPEAT_TICKS = 4,
    parameter int CNT_W        = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               move_tick,
    input  logic               up,
    input  logic               down,
    input  logic               left,
    input  logic               right,
    output logic               wall_req,
    output logic [COORD_W-1:0] wall_x,
    output logic [COORD_W-1:0] wall_y,
    input  logic               wall_ack,
    input  logic               wall_is_wall,
    output logic [COORD_W-1:0] player_x,
    output logic [COORD_W-1:0] player_y,
    output logic               hit_wall,
    output logic               busy,
    output logic [CNT_W-1:0]   move_count
);

    localparam int HW = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;
    localparam logic [HW-1:0]      HOLD_RELOAD = HW'(REPEAT_TICKS - 1);
    localparam logic [HW-1:0]      HOLD_ONE    = HW'(1);
    localparam logic [COORD_W-1:0] X_MAX       = COORD_W'(MAZE_W - 1);
    localparam logic [COORD_W-1:0] Y_MAX       = COORD_W'(MAZE_H - 1);
    localparam logic [COORD_W-1:0] ONE         = COORD_W'(1);
    localparam logic [CNT_W-1:0]   CNT_ONE     = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [HW-1:0]      hold;
    logic               any_dir;
    logic               accept;
    logic               at_edge;
    logic [COORD_W-1:0] tgt_x;
    logic [COORD_W-1:0] tgt_y;

    assign any_dir  = up | down | left | right;
    assign accept   = (state == IDLE) && move_tick && any_dir && (hold == '0);
    assign wall_req = (state == REQ);
    assign busy     = (state != IDLE);

    // Fixed priority up > down > left > right, one axis only.
    always_comb begin
        tgt_x   = player_x;
        tgt_y   = player_y;
        at_edge = 1'b0;
        if (up) begin
            at_edge = (player_y == '0);
            tgt_y   = player_y - ONE;
        end else if (down) begin
            at_edge = (player_y == Y_MAX);
            tgt_y   = player_y + ONE;
        end else if (left) begin
            at_edge = (player_x == '0);
            tgt_x   = player_x - ONE;
        end else if (right) begin
            at_edge = (player_x == X_MAX);
            tgt_x   = player_x + ONE;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept && !at_edge) state_nx = REQ;
            REQ:     if (wall_ack) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            player_x   <= COORD_W'(START_X);
            player_y   <= COORD_W'(START_Y);
            wall_x     <= '0;
            wall_y     <= '0;
            hit_wall   <= 1'b0;
            move_count <= '0;
            hold       <= '0;
        end else begin
            hit_wall <= 1'b0;
            // Ticks while busy are dropped and do not age the hold-off.
            if (!any_dir) begin
                hold <= '0;
            end else if (state == IDLE && move_tick) begin
                hold <= (hold == '0) ? HOLD_RELOAD : hold - HOLD_ONE;
            end
            if (accept) begin
                if (at_edge) begin
                    hit_wall <= 1'b1;
                end else begin
                    wall_x <= tgt_x;
                    wall_y <= tgt_y;
                end
            end
            if (state == REQ && wall_ack) begin
                if (wall_is_wall) begin
                    hit_wall <= 1'b1;
                end else begin
                    player_x <= wall_x;
                    player_y <= wall_y;
                    if (move_count != {CNT_W{1'b1}}) begin
                        move_count <= move_count + CNT_ONE;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_maze_player_ctrl.sv
// Bench for maze_player_ctrl: per-cycle reference model plus directed scenarios.
// The DUT uses a 2-bit move counter so saturation is reachable.
module tb_maze_player_ctrl;

    localparam int MW   = 40;
    localparam int MH   = 30;
    localparam int REP  = 4;
    localparam int CMAX = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        move_tick = 1'b0;
    logic        up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
    logic        wall_req;
    logic [10:0] wall_x, wall_y;
    logic        wall_ack, wall_is_wall;
    logic [10:0] player_x, player_y;
    logic        hit_wall, busy;
    logic [1:0]  move_count;

    logic resp_ack = 1'b0, resp_wall = 1'b0;
    logic stray_ack = 1'b0, stray_wall = 1'b0;
    int   ack_delay = 0;
    int   rcnt = 0;
    bit   wall_map [0:MW-1][0:MH-1];

    int total = 0;
    int bad = 0;
    int hits = 0;
    int reqs = 0;
    logic prev_req = 1'b0;

    int m_x, m_y, m_cnt, m_hold, m_wx, m_wy;
    bit m_req, m_tail, m_hit;

    assign wall_ack     = resp_ack | stray_ack;
    assign wall_is_wall = resp_ack ? resp_wall : stray_wall;

    maze_player_ctrl #(.CNT_W(2)) dut (
        .clk(clk), .reset_n(rst_n), .move_tick(move_tick),
        .up(up), .down(down), .left(left), .right(right),
        .wall_req(wall_req), .wall_x(wall_x), .wall_y(wall_y),
        .wall_ack(wall_ack), .wall_is_wall(wall_is_wall),
        .player_x(player_x), .player_y(player_y),
        .hit_wall(hit_wall), .busy(busy), .move_count(move_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_x = 1; m_y = 1; m_cnt = 0; m_hold = 0;
        m_wx = 0; m_wy = 0;
        m_req = 0; m_tail = 0; m_hit = 0;
    endtask

    // Reference model: advances on each rising edge from the sampled inputs.
    initial begin
        bit anyd;
        int dx, dy, nx, ny;
        m_reset();
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_reset();
            end else begin
                anyd  = up | down | left | right;
                m_hit = 0;
                if (m_req) begin
                    if (wall_ack) begin
                        m_req  = 0;
                        m_tail = 1;
                        if (wall_is_wall) m_hit = 1;
                        else begin
                            m_x = m_wx; m_y = m_wy;
                            if (m_cnt < CMAX) m_cnt++;
                        end
                    end
                end else if (m_tail) begin
                    m_tail = 0;
                end else if (move_tick && anyd) begin
                    if (m_hold == 0) begin
                        dx = 0; dy = 0;
                        if (up) dy = -1;
                        else if (down) dy = 1;
                        else if (left) dx = -1;
                        else dx = 1;
                        nx = m_x + dx;
                        ny = m_y + dy;
                        if (nx < 0 || nx >= MW || ny < 0 || ny >= MH) m_hit = 1;
                        else begin
                            m_req = 1; m_wx = nx; m_wy = ny;
                        end
                        m_hold = REP - 1;
                    end else begin
                        m_hold--;
                    end
                end
                if (!anyd) m_hold = 0;
            end
        end
    end

    // Compare process, mid-cycle on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) m_reset();
            chk("player_x", player_x, m_x);
            chk("player_y", player_y, m_y);
            chk("move_count", move_count, m_cnt);
            chk("hit_wall", hit_wall, m_hit);
            chk("busy", busy, m_req | m_tail);
            chk("wall_req", wall_req, m_req);
            if (m_req) begin
                chk("wall_x", wall_x, m_wx);
                chk("wall_y", wall_y, m_wy);
            end
            if (hit_wall) hits++;
            if (wall_req && !prev_req) reqs++;
            prev_req = wall_req;
        end
    end

    // Wall memory responder: ack after ack_delay cycles of wall_req.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (wall_req) begin
                if (rcnt == ack_delay) begin
                    resp_ack = 1'b1;
                    resp_wall = (wall_x < MW && wall_y < MH) ? wall_map[wall_x][wall_y] : 1'b0;
                    rcnt = 0;
                end else begin
                    resp_ack = 1'b0;
                    rcnt++;
                end
            end else begin
                resp_ack = 1'b0;
                rcnt = 0;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic dirs(input logic u, input logic d, input logic l, input logic r);
        up = u; down = d; left = l; right = r;
    endtask

    task automatic tick_one();
        move_tick = 1'b1;
        cyc(1);
        move_tick = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 40) begin
            cyc(1);
            n++;
        end
        if (busy) chk("idle_timeout", 1, 0);
    endtask

    initial begin
        int h0, r0;
        for (int i = 0; i < MW; i++)
            for (int j = 0; j < MH; j++)
                wall_map[i][j] = 1'b0;
        wall_map[1][2] = 1'b1;

        cyc(3);
        chk("rst_x", player_x, 1);
        chk("rst_y", player_y, 1);
        chk("rst_cnt", move_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_req", wall_req, 0);
        chk("rst_wx", wall_x, 0);
        rst_n = 1'b1;
        cyc(2);

        // Wall hit from (1,1) going down
        h0 = hits;
        ack_delay = 1;
        dirs(0, 1, 0, 0);
        tick_one();
        wait_idle();
        dirs(0, 0, 0, 0);
        cyc(2);
        chk("wall_pulses", hits - h0, 1);
        chk("wall_x_pos", player_x, 1);
        chk("wall_y_pos", player_y, 1);
        chk("wall_cnt", move_count, 0);

        // Stray ack in idle is ignored
        stray_ack = 1'b1;
        cyc(1);
        stray_ack = 1'b0;
        cyc(2);
        chk("stray_x", player_x, 1);
        chk("stray_busy", busy, 0);

        // Free move right, ack at N+3
        ack_delay = 2;
        dirs(0, 0, 0, 1);
        tick_one();
        chk("free_req", wall_req, 1);
        chk("free_wx", wall_x, 2);
        chk("free_wy", wall_y, 1);
        cyc(2);
        chk("free_x_n3", player_x, 1);
        cyc(1);
        chk("free_x_n4", player_x, 2);
        chk("free_cnt", move_count, 1);
        dirs(0, 0, 0, 0);
        wait_idle();
        cyc(1);

        // Walk to (0,5): left twice, down four times
        ack_delay = 0;
        for (int k = 0; k < 6; k++) begin
            if (k < 2) dirs(0, 0, 1, 0);
            else dirs(0, 1, 0, 0);
            tick_one();
            wait_idle();
            dirs(0, 0, 0, 0);
            cyc(1);
        end
        chk("walk_x", player_x, 0);
        chk("walk_y", player_y, 5);
        chk("sat_cnt", move_count, 3);

        // Left edge: no lookup, single hit pulse
        r0 = reqs;
        h0 = hits;
        dirs(0, 0, 1, 0);
        tick_one();
        chk("edge_hit", hit_wall, 1);
        cyc(3);
        dirs(0, 0, 0, 0);
        cyc(1);
        chk("edge_noreq", reqs - r0, 0);
        chk("edge_pulses", hits - h0, 1);
        chk("edge_x", player_x, 0);

        // up+left: up wins
        dirs(1, 0, 1, 0);
        tick_one();
        wait_idle();
        dirs(0, 0, 0, 0);
        cyc(1);
        chk("prio_x", player_x, 0);
        chk("prio_y", player_y, 4);

        // Auto-repeat: 9 ticks held, moves on ticks 1,5,9
        r0 = reqs;
        dirs(0, 0, 0, 1);
        for (int k = 0; k < 9; k++) begin
            tick_one();
            cyc(3);
        end
        dirs(0, 0, 0, 0);
        cyc(1);
        chk("rep_x", player_x, 3);
        chk("rep_reqs", reqs - r0, 3);
        chk("rep_sat", move_count, 3);

        // Reset mid-lookup
        ack_delay = 6;
        dirs(0, 1, 0, 0);
        tick_one();
        cyc(1);
        chk("mid_req", wall_req, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_req_now", wall_req, 0);
        chk("rst_x_now", player_x, 1);
        cyc(2);
        rst_n = 1'b1;
        dirs(0, 0, 0, 0);
        cyc(3);
        chk("post_x", player_x, 1);
        chk("post_y", player_y, 1);
        chk("post_cnt", move_count, 0);
        chk("post_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
